// File: rtl/cache_miss_handler_if.sv
// Miss-handler bus bundle: miss request with victim state, memory beat port,
// and cache-array fill port. The handler uses the master modport; the
// lookup path / memory side uses the slave modport.
interface cache_miss_handler_if #(
    parameter int TAG_BITS        = 18,
    parameter int INDEX_BITS      = 8,
    parameter int LINE_SIZE_BYTES = 64,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int WAYS            = 4
);
    localparam int LINE_BITS = LINE_SIZE_BYTES * 8;
    localparam int WAY_BITS  = $clog2(WAYS);

    logic                     i_miss_valid;
    logic                     o_miss_ready;
    logic [TAG_BITS-1:0]      i_miss_tag;
    logic [INDEX_BITS-1:0]    i_miss_index;
    logic [WAY_BITS-1:0]      i_victim_way;
    logic                     i_victim_valid;
    logic                     i_victim_dirty;
    logic [TAG_BITS-1:0]      i_victim_tag;
    logic [LINE_BITS-1:0]     i_victim_data;

    logic                     o_mem_req;
    logic                     o_mem_we;
    logic [ADDRESS_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0]    o_mem_wdata;
    logic                     i_mem_ack;
    logic [DATA_WIDTH-1:0]    i_mem_rdata;

    logic                     o_fill_valid;
    logic [WAY_BITS-1:0]      o_fill_way;
    logic [INDEX_BITS-1:0]    o_fill_index;
    logic [TAG_BITS-1:0]      o_fill_tag;
    logic [LINE_BITS-1:0]     o_fill_data;
    logic                     o_busy;

    modport master (
        input  i_miss_valid, i_miss_tag, i_miss_index, i_victim_way,
               i_victim_valid, i_victim_dirty, i_victim_tag, i_victim_data,
               i_mem_ack, i_mem_rdata,
        output o_miss_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
               o_fill_valid, o_fill_way, o_fill_index, o_fill_tag, o_fill_data,
               o_busy
    );

    modport slave (
        output i_miss_valid, i_miss_tag, i_miss_index, i_victim_way,
               i_victim_valid, i_victim_dirty, i_victim_tag, i_victim_data,
               i_mem_ack, i_mem_rdata,
        input  o_miss_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
               o_fill_valid, o_fill_way, o_fill_index, o_fill_tag, o_fill_data,
               o_busy
    );
endinterface

// File: rtl/cache_miss_handler.sv
// Refill / writeback engine for the set-associative cache.
// Writes back a dirty victim beat by beat, fetches the missing line beat by
// beat, then issues a one-cycle fill write of the assembled line.
//
// state | meaning
// IDLE  | waiting for a miss; o_miss_ready high
// WB    | writing victim line to memory, one beat per ack
// FETCH | reading missing line from memory, one beat per ack
// FILL  | one-cycle fill strobe to the cache array
module cache_miss_handler #(
    parameter int TAG_BITS        = 18,
    parameter int INDEX_BITS      = 8,
    parameter int OFFSET_BITS     = 6,
    parameter int LINE_SIZE_BYTES = 64,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int WAYS            = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_miss_handler_if.master  bus
);
    localparam int LINE_BITS  = LINE_SIZE_BYTES * 8;
    localparam int BEATS      = LINE_BITS / DATA_WIDTH;
    localparam int BEAT_BITS  = $clog2(BEATS);
    localparam int WAY_BITS   = $clog2(WAYS);
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, WB, FETCH, FILL} state_t;

    state_t                   state_q, state_d;
    logic [BEAT_BITS-1:0]     beat_q, beat_d;
    logic [TAG_BITS-1:0]      tag_q, tag_d;
    logic [INDEX_BITS-1:0]    index_q, index_d;
    logic [WAY_BITS-1:0]      way_q, way_d;
    logic [TAG_BITS-1:0]      vtag_q, vtag_d;
    logic [LINE_BITS-1:0]     vdata_q, vdata_d;
    logic [LINE_BITS-1:0]     line_q, line_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [BEAT_BITS-1:0]     beat_nxt;

    assign beat_nxt = beat_q + BEAT_BITS'(1);

    function automatic logic [ADDRESS_WIDTH-1:0] beat_addr(
        input logic [TAG_BITS-1:0]   tag,
        input logic [INDEX_BITS-1:0] index,
        input logic [BEAT_BITS-1:0]  beat
    );
        logic [OFFSET_BITS-1:0] offset;
        offset = OFFSET_BITS'(beat) << BYTE_SHIFT;
        return {tag, index, offset};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] word_of(
        input logic [LINE_BITS-1:0] line,
        input logic [BEAT_BITS-1:0] beat
    );
        return line[int'(beat)*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    // Next-state, beat counter and registered memory address/data.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tag_d   = tag_q;
        index_d = index_q;
        way_d   = way_q;
        vtag_d  = vtag_q;
        vdata_d = vdata_q;
        line_d  = line_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.i_miss_valid) begin
                    tag_d   = bus.i_miss_tag;
                    index_d = bus.i_miss_index;
                    way_d   = bus.i_victim_way;
                    vtag_d  = bus.i_victim_tag;
                    vdata_d = bus.i_victim_data;
                    beat_d  = '0;
                    if (bus.i_victim_valid && bus.i_victim_dirty) begin
                        state_d = WB;
                        addr_d  = beat_addr(bus.i_victim_tag, bus.i_miss_index, '0);
                        wdata_d = bus.i_victim_data[DATA_WIDTH-1:0];
                    end else begin
                        state_d = FETCH;
                        addr_d  = beat_addr(bus.i_miss_tag, bus.i_miss_index, '0);
                        wdata_d = '0;
                    end
                end
            end
            WB: begin
                if (bus.i_mem_ack) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = FETCH;
                        addr_d  = beat_addr(tag_q, index_q, '0);
                        wdata_d = '0;
                    end else begin
                        beat_d  = beat_nxt;
                        addr_d  = beat_addr(vtag_q, index_q, beat_nxt);
                        wdata_d = word_of(vdata_q, beat_nxt);
                    end
                end
            end
            FETCH: begin
                if (bus.i_mem_ack) begin
                    line_d[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] = bus.i_mem_rdata;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = FILL;
                    end else begin
                        beat_d = beat_nxt;
                        addr_d = beat_addr(tag_q, index_q, beat_nxt);
                    end
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            tag_q   <= '0;
            index_q <= '0;
            way_q   <= '0;
            vtag_q  <= '0;
            vdata_q <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tag_q   <= tag_d;
            index_q <= index_d;
            way_q   <= way_d;
            vtag_q  <= vtag_d;
            vdata_q <= vdata_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.o_miss_ready = (state_q == IDLE) && !rst;
    assign bus.o_busy       = (state_q != IDLE);
    assign bus.o_mem_req    = (state_q == WB) || (state_q == FETCH);
    assign bus.o_mem_we     = (state_q == WB);
    assign bus.o_mem_addr   = addr_q;
    assign bus.o_mem_wdata  = wdata_q;
    assign bus.o_fill_valid = (state_q == FILL);
    assign bus.o_fill_way   = way_q;
    assign bus.o_fill_index = index_q;
    assign bus.o_fill_tag   = tag_q;
    assign bus.o_fill_data  = line_q;
endmodule
